// File: rtl/linebuf_window9.sv
// rtl/linebuf_window9.sv - 9x9 sliding-window generator over a raster pixel stream
// Eight chained line buffers feed the new right-hand column of a 9x9 shift register.
module linebuf_window9 #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] pix_in,
  input  logic       pix_valid,
  input  logic       pix_sof,
  output logic       pix_ready,
  output logic [6:0] xarray [0:80],
  output logic       win_valid,
  input  logic       win_ready,
  output logic       frame_done
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic          r_win_valid;
  logic          r_frame_done;
  logic [6:0]    r_win [0:80];
  logic [6:0]    r_lb [0:7][0:IMG_W-1];

  logic          w_acc;
  logic [CW-1:0] w_col;
  logic [RW-1:0] w_row;
  logic          w_col_last;
  logic          w_row_last;
  logic          w_win_done;
  logic [6:0]    w_new_col [0:8];

  assign pix_ready = rst_n && (!r_win_valid || win_ready);
  assign w_acc     = pix_valid && pix_ready;

  // A start-of-frame pixel lands at (0,0) whatever the counters hold.
  assign w_col      = pix_sof ? '0 : r_col;
  assign w_row      = pix_sof ? '0 : r_row;
  assign w_col_last = (w_col == CW'(IMG_W - 1));
  assign w_row_last = (w_row == RW'(IMG_H - 1));
  assign w_win_done = w_acc && (w_row >= RW'(8)) && (w_col >= CW'(8));

  always_comb begin
    for (int k = 0; k < 8; k++) begin
      w_new_col[k] = r_lb[7-k][w_col];
    end
    w_new_col[8] = pix_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_col        <= '0;
      r_row        <= '0;
      r_frame_done <= 1'b0;
      r_win_valid  <= 1'b0;
    end else begin
      r_frame_done <= w_acc && w_col_last && w_row_last;
      if (w_acc) begin
        if (w_col_last) begin
          r_col <= '0;
          r_row <= w_row_last ? '0 : w_row + RW'(1);
        end else begin
          r_col <= w_col + CW'(1);
          r_row <= w_row;
        end
      end
      if (w_win_done) begin
        r_win_valid <= 1'b1;
      end else if (win_ready) begin
        r_win_valid <= 1'b0;
      end
    end
  end

  // pix_ready stalls while a window is pending, so shifting never clobbers an untaken window.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 81; i++) begin
        r_win[i] <= '0;
      end
    end else if (w_acc) begin
      for (int r = 0; r < 9; r++) begin
        for (int c = 0; c < 8; c++) begin
          r_win[r*9+c] <= r_win[r*9+c+1];
        end
        r_win[r*9+8] <= w_new_col[r];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_lb[0][w_col] <= pix_in;
      for (int k = 1; k < 8; k++) begin
        r_lb[k][w_col] <= r_lb[k-1][w_col];
      end
    end
  end

  assign xarray     = r_win;
  assign win_valid  = r_win_valid;
  assign frame_done = r_frame_done;

endmodule
